// File: rtl/alu.sv
// alu: EX-stage integer ALU with a registered result and Zero flag (one-cycle latency).
// Defining ALU_OVERFLOW_EN adds a registered signed-overflow output for ADD/SUB.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] ALU_input_1,
    input  logic [WIDTH-1:0] ALU_input_2,
    input  logic [3:0]       func,
    output logic [WIDTH-1:0] ALU_Result,
`ifdef ALU_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             Zero
);

    localparam logic [2:0] CTRL_RTYPE = 3'b000;
    localparam logic [2:0] CTRL_ADD   = 3'b001;
    localparam logic [2:0] CTRL_SUB   = 3'b010;
    localparam logic [2:0] CTRL_AND   = 3'b011;
    localparam logic [2:0] CTRL_OR    = 3'b100;
    localparam logic [2:0] CTRL_SLT   = 3'b101;
    localparam logic [2:0] CTRL_LUI   = 3'b110;
    localparam logic [2:0] CTRL_PASSB = 3'b111;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_AND  = 4'b0010;
    localparam logic [3:0] FN_OR   = 4'b0011;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_NOR  = 4'b0101;
    localparam logic [3:0] FN_SLT  = 4'b0110;
    localparam logic [3:0] FN_SLTU = 4'b0111;
    localparam logic [3:0] FN_SLL  = 4'b1000;
    localparam logic [3:0] FN_SRL  = 4'b1001;
    localparam logic [3:0] FN_SRA  = 4'b1010;
    localparam logic [3:0] FN_ROL  = 4'b1011;

    localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] flag_ext(input logic flag_v);
        return {{(WIDTH-1){1'b0}}, flag_v};
    endfunction

    logic [3:0]         shamt_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [2*WIDTH-1:0] rol_wide_s;
    logic [WIDTH-1:0]   rol_s;
    logic               slt_s;
    logic               sltu_s;
    logic [WIDTH-1:0]   result_s;

    // Shared arithmetic terms; rotate is the upper half of a doubled operand shifted left.
    always_comb begin
        shamt_s    = ALU_input_2[3:0];
        sum_s      = ALU_input_1 + ALU_input_2;
        diff_s     = ALU_input_1 - ALU_input_2;
        rol_wide_s = {ALU_input_1, ALU_input_1} << shamt_s;
        rol_s      = rol_wide_s[2*WIDTH-1:WIDTH];
        slt_s      = ($signed(ALU_input_1) < $signed(ALU_input_2));
        sltu_s     = (ALU_input_1 < ALU_input_2);
    end

    // Operation decode: ALU_control picks the class, func refines R-type.
    always_comb begin
        result_s = ZERO_WORD;
        case (ALU_control)
            CTRL_RTYPE: begin
                case (func)
                    FN_ADD:  result_s = sum_s;
                    FN_SUB:  result_s = diff_s;
                    FN_AND:  result_s = ALU_input_1 & ALU_input_2;
                    FN_OR:   result_s = ALU_input_1 | ALU_input_2;
                    FN_XOR:  result_s = ALU_input_1 ^ ALU_input_2;
                    FN_NOR:  result_s = ~(ALU_input_1 | ALU_input_2);
                    FN_SLT:  result_s = flag_ext(slt_s);
                    FN_SLTU: result_s = flag_ext(sltu_s);
                    FN_SLL:  result_s = ALU_input_1 << shamt_s;
                    FN_SRL:  result_s = ALU_input_1 >> shamt_s;
                    FN_SRA:  result_s = $signed(ALU_input_1) >>> shamt_s;
                    FN_ROL:  result_s = rol_s;
                    default: result_s = ZERO_WORD;
                endcase
            end
            CTRL_ADD:   result_s = sum_s;
            CTRL_SUB:   result_s = diff_s;
            CTRL_AND:   result_s = ALU_input_1 & ALU_input_2;
            CTRL_OR:    result_s = ALU_input_1 | ALU_input_2;
            CTRL_SLT:   result_s = flag_ext(slt_s);
            CTRL_LUI:   result_s = ALU_input_2 << 4'd8;
            CTRL_PASSB: result_s = ALU_input_2;
            default:    result_s = ZERO_WORD;
        endcase
    end

    // Result and Zero register; Zero derives from the value being captured, not the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_Result <= ZERO_WORD;
            Zero       <= 1'b1;
        end else begin
            ALU_Result <= result_s;
            Zero       <= (result_s == ZERO_WORD);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic add_op_s;
    logic sub_op_s;
    logic ovf_s;

    // Signed overflow: add of like signs, or sub of unlike signs, flipping A's sign.
    always_comb begin
        add_op_s = (ALU_control == CTRL_ADD) || ((ALU_control == CTRL_RTYPE) && (func == FN_ADD));
        sub_op_s = (ALU_control == CTRL_SUB) || ((ALU_control == CTRL_RTYPE) && (func == FN_SUB));
        if (add_op_s) begin
            ovf_s = (ALU_input_1[WIDTH-1] == ALU_input_2[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != ALU_input_1[WIDTH-1]);
        end else if (sub_op_s) begin
            ovf_s = (ALU_input_1[WIDTH-1] != ALU_input_2[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != ALU_input_1[WIDTH-1]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Overflow register, captured alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Overflow <= 1'b0;
        end else begin
            Overflow <= ovf_s;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expectations, a monitor pops them one edge later.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [2:0]  ALU_control;
    logic [15:0] ALU_input_1;
    logic [15:0] ALU_input_2;
    logic [3:0]  func;
    logic [15:0] ALU_Result;
    logic        Zero;
`ifdef ALU_OVERFLOW_EN
    logic        Overflow;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic        ovf;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
                  OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_LUI, OP_PASSB, OP_ZERO} op_e;

    alu dut (
        .clk         (clk),
        .rst         (rst),
        .ALU_control (ALU_control),
        .ALU_input_1 (ALU_input_1),
        .ALU_input_2 (ALU_input_2),
        .func        (func),
        .ALU_Result  (ALU_Result),
`ifdef ALU_OVERFLOW_EN
        .Overflow    (Overflow),
`endif
        .Zero        (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic op_e decode(input logic [2:0] c, input logic [3:0] f);
        op_e rtype[16] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
                           OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ZERO, OP_ZERO, OP_ZERO, OP_ZERO};
        op_e cls[8] = '{OP_ZERO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LUI, OP_PASSB};
        if (c == 3'd0) return rtype[f];
        return cls[c];
    endfunction

    // Reference model using plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] c, input logic [3:0] f,
                                   input logic [15:0] a16, input logic [15:0] b16, input string tag);
        exp_t e;
        int a, b, sa, sb, sh, r, wide;
        op_e op;
        a  = int'(a16);
        b  = int'(b16);
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sh = b % 16;
        op = decode(c, f);
        r = 0;
        e.ovf = 1'b0;
        case (op)
            OP_ADD:   begin r = (a + b) % 65536; wide = sa + sb;
                            e.ovf = (wide > 32767) || (wide < -32768); end
            OP_SUB:   begin r = (a - b + 65536) % 65536; wide = sa - sb;
                            e.ovf = (wide > 32767) || (wide < -32768); end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = 65535 - (a | b);
            OP_SLT:   r = (sa < sb) ? 1 : 0;
            OP_SLTU:  r = (a < b) ? 1 : 0;
            OP_SLL:   r = (a * (1 << sh)) % 65536;
            OP_SRL:   r = a / (1 << sh);
            OP_SRA:   r = (sa >>> sh) & 32'h0000_FFFF;
            OP_ROL:   r = ((a * (1 << sh)) % 65536) | (a / (1 << (16 - sh)));
            OP_LUI:   r = (b * 256) % 65536;
            OP_PASSB: r = b;
            default:  r = 0;
        endcase
        e.res  = 16'(r);
        e.zero = (r == 0);
        e.tag  = tag;
        return e;
    endfunction

    // Drive one operation at the falling edge; a nonzero has_lit replaces the model's result.
    task automatic issue(input logic [2:0] c, input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] b, input string tag, input bit has_lit,
                         input logic [15:0] lit);
        exp_t e;
        @(negedge clk);
        ALU_control = c;
        func        = f;
        ALU_input_1 = a;
        ALU_input_2 = b;
        e = model(c, f, a, b, tag);
        if (has_lit) begin
            e.res  = lit;
            e.zero = (lit == 16'h0000);
        end
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [15:0] er, input logic ez);
        checks++;
        if (ALU_Result !== er) begin
            failures++;
            $display("FAIL %s: ALU_Result got %h expected %h", tag, ALU_Result, er);
        end
        checks++;
        if (Zero !== ez) begin
            failures++;
            $display("FAIL %s: Zero got %b expected %b", tag, Zero, ez);
        end
    endtask

    // Monitor: every edge with an outstanding expectation produces exactly one result.
    always @(posedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            check_now(e.tag, e.res, e.zero);
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (Overflow !== e.ovf) begin
                failures++;
                $display("FAIL %s: Overflow got %b expected %b", e.tag, Overflow, e.ovf);
            end
`endif
        end
    end

    initial begin
        rst = 1'b0;
        ALU_control = 3'd0;
        func = 4'd0;
        ALU_input_1 = 16'd0;
        ALU_input_2 = 16'd0;

        #1;
        ALU_control = 3'd1;
        ALU_input_1 = 16'h1234;
        ALU_input_2 = 16'h0001;
        rst = 1'b1;
        #1;
        check_now("reset_async", 16'h0000, 1'b1);
        repeat (2) @(negedge clk);
        check_now("reset_hold", 16'h0000, 1'b1);
        rst = 1'b0;
        #1;
        check_now("reset_release", 16'h0000, 1'b1);

        issue(3'd0, 4'd8,  16'd12,   16'd43,   "sll_12_by_11", 1'b1, 16'h6000);
        issue(3'd0, 4'd10, 16'h8000, 16'd4,    "sra_8000_4",   1'b1, 16'hF800);
        issue(3'd1, 4'd0,  16'hFFFF, 16'd1,    "add_wrap",     1'b1, 16'h0000);
        issue(3'd2, 4'd3,  16'd5,    16'd5,    "sub_equal",    1'b1, 16'h0000);
        issue(3'd1, 4'd9,  16'h7FFF, 16'd1,    "add_ovf",      1'b1, 16'h8000);
        issue(3'd0, 4'd6,  16'hFFFE, 16'd3,    "slt_neg",      1'b1, 16'h0001);
        issue(3'd0, 4'd7,  16'hFFFE, 16'd3,    "sltu_big",     1'b1, 16'h0000);
        issue(3'd0, 4'd5,  16'h00F0, 16'h0F00, "nor",          1'b1, 16'hF00F);
        issue(3'd6, 4'd2,  16'hAAAA, 16'h0012, "lui",          1'b1, 16'h1200);
        issue(3'd0, 4'd11, 16'h8001, 16'd1,    "rol_8001_1",   1'b1, 16'h0003);
        issue(3'd0, 4'd15, 16'h1234, 16'h5678, "reserved",     1'b1, 16'h0000);
        issue(3'd0, 4'd8,  16'hABCD, 16'h0010, "shift_zero",   1'b1, 16'hABCD);
        issue(3'd5, 4'd0,  16'h8000, 16'h7FFF, "slti",         1'b1, 16'h0001);
        issue(3'd2, 4'd0,  16'h8000, 16'd1,    "sub_ovf",      1'b1, 16'h7FFF);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom),
                  16'($urandom), "random", 1'b0, 16'h0000);
        end

        issue(3'd7, 4'd0, 16'h0000, 16'h5A5A, "pre_reset", 1'b1, 16'h5A5A);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now("reset_mid", 16'h0000, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_now("reset_mid_hold", 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom),
                  16'($urandom), "random_post", 1'b0, 16'h0000);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
